// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory responder: access size codes,
//   responder FSM states and the alignment helper.
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Half accesses need an even address, words a 4-byte aligned one.
   function automatic logic size_aligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
      case (size)
         SZ_HALF: return ~addr_lo[0];
         SZ_WORD: return (addr_lo == 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lane_ctrl
//   Combinational little-endian lane steering for byte/half/word accesses.
//   Ports:
//     size       in   access size code (SZ_*)
//     addr_lo    in   byte address bits [1:0]
//     wdata      in   store data, right-justified
//     rword      in   32-bit word read from the array
//     byte_en    out  per-byte write enables
//     wdata_lane out  store data replicated onto its lanes
//     rdata_ext  out  selected load data, sign-extended to 32 bits
//     misalign   out  address is not aligned for the size
// -----------------------------------------------------------------------------
module dmem_lane_ctrl
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      byte_en    = '0;
      wdata_lane = '0;
      rdata_ext  = '0;
      misalign   = ~size_aligned(size, addr_lo);
      rbyte      = rword[{addr_lo, 3'b000} +: 8];
      rhalf      = addr_lo[1] ? rword[31:16] : rword[15:0];
      case (size)
         SZ_BYTE: begin
            byte_en    = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {{24{rbyte[7]}}, rbyte};
         end
         SZ_HALF: begin
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = {{16{rhalf[15]}}, rhalf};
         end
         SZ_WORD: begin
            byte_en    = 4'b1111;
            wdata_lane = wdata;
            rdata_ext  = rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the core data port. Accepts one load or store
//   at a time, waits LATENCY cycles, commits to an internal little-endian
//   array and returns a single-cycle response.
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   asynchronous active-low reset
//     req_valid    in   request present
//     req_ready    out  request can be accepted this cycle
//     req_memread  in   load size (SZ_*)
//     req_memwrite in   store size (SZ_*)
//     req_addr     in   byte address (upper bits wrap)
//     req_wdata    in   store data
//     resp_valid   out  one-cycle response pulse
//     resp_rdata   out  sign-extended load data, 0 for stores/errors
//     resp_err     out  request was illegal, no memory effect
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_memread,
   input  logic [1:0]  req_memwrite,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IW       = ADDR_BITS - 2;
   localparam int unsigned WORDS    = 2 ** IW;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [1:0]           rd_q, rd_d;
   logic [1:0]           wr_q, wr_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic [31:0]          mem_q [WORDS];

   logic                 accept, commit, mem_we, acc_err;
   logic [ADDR_BITS-1:0] acc_addr;
   logic [31:0]          acc_wdata;
   logic [1:0]           acc_rd, acc_wr, acc_size;
   logic [IW-1:0]        mem_idx;
   logic [31:0]          rword, wlane, lval;
   logic [3:0]           byte_en;
   logic                 misalign;

   logic                 unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_BITS];

   // With single-cycle latency the commit happens on the accept edge itself,
   // so the access must be taken from the live request, not the capture regs.
   always_comb begin
      if (LATENCY == 1) begin
         acc_addr  = req_addr[ADDR_BITS-1:0];
         acc_wdata = req_wdata;
         acc_rd    = req_memread;
         acc_wr    = req_memwrite;
      end else begin
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_rd    = rd_q;
         acc_wr    = wr_q;
      end
      acc_size = (acc_rd != SZ_NONE) ? acc_rd : acc_wr;
      mem_idx  = acc_addr[ADDR_BITS-1:2];
      rword    = mem_q[mem_idx];
   end

   dmem_lane_ctrl u_lane (
      .size       (acc_size),
      .addr_lo    (acc_addr[1:0]),
      .wdata      (acc_wdata),
      .rword      (rword),
      .byte_en    (byte_en),
      .wdata_lane (wlane),
      .rdata_ext  (lval),
      .misalign   (misalign)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      rdata_d   = rdata_q;
      err_d     = err_q;

      req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
      accept    = req_valid && req_ready &&
                  ((req_memread != SZ_NONE) || (req_memwrite != SZ_NONE));

      case (state_q)
         ST_IDLE: if (accept) state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (accept) state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            else        state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         addr_d  = req_addr[ADDR_BITS-1:0];
         wdata_d = req_wdata;
         rd_d    = req_memread;
         wr_d    = req_memwrite;
         cnt_d   = CNT_LOAD;
      end

      // Loads and stores both commit on the edge that enters RESP.
      commit  = (state_d == ST_RESP);
      acc_err = ((acc_rd != SZ_NONE) && (acc_wr != SZ_NONE)) || misalign;
      mem_we  = commit && reset && !acc_err && (acc_rd == SZ_NONE);
      if (commit) begin
         err_d   = acc_err;
         rdata_d = (!acc_err && (acc_rd != SZ_NONE)) ? lval : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= SZ_NONE;
         wr_q    <= SZ_NONE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) mem_q[mem_idx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder using a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int unsigned ADDR_BITS = 8;
   localparam int unsigned LATENCY   = 2;
   localparam int unsigned MEM_BYTES = 256;
   localparam int unsigned MAX_WAIT  = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_memread = 2'b00;
   logic [1:0]  req_memwrite = 2'b00;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   logic [7:0]  ref_mem [MEM_BYTES];

   dmem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_memread  (req_memread),
      .req_memwrite (req_memwrite),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic int unsigned nbytes(input logic [1:0] sz);
      return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
   endfunction

   // Reference: predict the response and apply any store to the byte array.
   task automatic model_access(input logic [1:0] rd, input logic [1:0] wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] exp_d, output logic exp_e);
      int unsigned a, n;
      logic [1:0] sz;
      sz    = (rd != 2'b00) ? rd : wr;
      a     = int'(addr) % MEM_BYTES;
      n     = nbytes(sz);
      exp_e = ((rd != 2'b00) && (wr != 2'b00)) || ((a % n) != 0);
      exp_d = '0;
      if (!exp_e && rd != 2'b00) begin
         for (int unsigned i = 0; i < n; i++) exp_d |= 32'(ref_mem[a+i]) << (8*i);
         if (n < 4 && exp_d[8*n-1]) exp_d |= 32'hFFFF_FFFF << (8*n);
      end else if (!exp_e) begin
         for (int unsigned i = 0; i < n; i++) ref_mem[a+i] = 8'(wdata >> (8*i));
      end
   endtask

   task automatic drive_req(input logic [1:0] rd, input logic [1:0] wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_memread  = rd;
      req_memwrite = wr;
      req_addr     = addr;
      req_wdata    = wdata;
   endtask

   // Counts negedges after the accept edge until resp_valid; bounded.
   task automatic wait_resp(input string tag);
      int unsigned lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < MAX_WAIT);
      check({tag, " latency"}, lat, LATENCY);
   endtask

   task automatic txn(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] obs_d, output logic obs_e);
      logic [31:0] exp_d;
      logic        exp_e;
      model_access(rd, wr, addr, wdata, exp_d, exp_e);
      @(negedge clk);
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      drive_req(rd, wr, addr, wdata);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_resp(tag);
      check({tag, " rdata"}, resp_rdata, exp_d);
      check({tag, " err"}, 32'(resp_err), 32'(exp_e));
      obs_d = resp_rdata;
      obs_e = resp_err;
   endtask

   initial begin
      logic [31:0] od, ea, eb, old20;
      logic        oe, ee;
      int unsigned lat, kind;
      logic [1:0]  rd, wr;
      logic [31:0] addr;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset ready", 32'(req_ready), 32'd1);
      check("reset valid", 32'(resp_valid), 32'd0);
      check("reset rdata", resp_rdata, 32'd0);
      check("reset err", 32'(resp_err), 32'd0);
      rst_n = 1'b1;

      // Give every word a known value
      for (int unsigned w = 0; w < MEM_BYTES / 4; w++)
         txn("init", 2'b00, 2'b11, 32'(w * 4), $urandom, od, oe);

      // Word store then load
      txn("st word", 2'b00, 2'b11, 32'h10, 32'hDEAD_BEEF, od, oe);
      check("st word rdata0", od, 32'd0);
      txn("ld word", 2'b11, 2'b00, 32'h10, 32'd0, od, oe);
      check("ld word value", od, 32'hDEAD_BEEF);

      // Byte and half lanes
      txn("st byte", 2'b00, 2'b01, 32'h13, 32'h0000_0080, od, oe);
      txn("ld word2", 2'b11, 2'b00, 32'h10, 32'd0, od, oe);
      check("ld word2 value", od, 32'h80AD_BEEF);
      txn("ld byte", 2'b01, 2'b00, 32'h13, 32'd0, od, oe);
      check("ld byte value", od, 32'hFFFF_FF80);
      txn("ld half", 2'b10, 2'b00, 32'h10, 32'd0, od, oe);
      check("ld half value", od, 32'hFFFF_BEEF);

      // Misaligned
      txn("misalign", 2'b11, 2'b00, 32'h12, 32'd0, od, oe);
      check("misalign err", 32'(oe), 32'd1);
      txn("st misalign", 2'b00, 2'b11, 32'h11, 32'h1234_5678, od, oe);
      txn("reread", 2'b11, 2'b00, 32'h10, 32'd0, od, oe);
      check("reread value", od, 32'h80AD_BEEF);

      // Idle request with both sizes zero
      @(negedge clk);
      drive_req(2'b00, 2'b00, 32'h10, 32'hFFFF_FFFF);
      repeat (4) begin
         @(negedge clk);
         check("noop valid", 32'(resp_valid), 32'd0);
         check("noop ready", 32'(req_ready), 32'd1);
      end
      req_valid = 1'b0;

      // Read and write together
      txn("rw both", 2'b11, 2'b01, 32'h20, 32'h0000_00AA, od, oe);
      check("rw both err", 32'(oe), 32'd1);
      txn("rw check", 2'b11, 2'b00, 32'h20, 32'd0, od, oe);

      // Back-to-back
      model_access(2'b00, 2'b11, 32'h40, 32'hCAFE_F00D, ea, ee);
      model_access(2'b11, 2'b00, 32'h40, 32'd0, eb, ee);
      @(negedge clk);
      drive_req(2'b00, 2'b11, 32'h40, 32'hCAFE_F00D);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_resp("b2b first");
      check("b2b first rdata", resp_rdata, ea);
      drive_req(2'b11, 2'b00, 32'h40, 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!resp_valid) check("b2b ready low", 32'(req_ready), 32'd0);
      end while (!resp_valid && lat < MAX_WAIT);
      check("b2b latency", lat, LATENCY);
      check("b2b rdata", resp_rdata, 32'hCAFE_F00D);
      check("b2b model", resp_rdata, eb);

      // Reset during BUSY discards the store
      model_access(2'b11, 2'b00, 32'h20, 32'd0, old20, ee);
      @(negedge clk);
      drive_req(2'b00, 2'b11, 32'h20, ~old20);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst ready", 32'(req_ready), 32'd1);
      check("rst valid", 32'(resp_valid), 32'd0);
      check("rst rdata", resp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LATENCY + 2) begin
         @(negedge clk);
         check("rst no resp", 32'(resp_valid), 32'd0);
      end
      txn("rst reload", 2'b11, 2'b00, 32'h20, 32'd0, od, oe);
      check("rst old value", od, old20);

      // Randomized traffic
      for (int unsigned k = 0; k < 150; k++) begin
         kind = $urandom_range(0, 9);
         rd   = 2'b00;
         wr   = 2'b00;
         if (kind < 4)      rd = 2'($urandom_range(1, 3));
         else if (kind < 8) wr = 2'($urandom_range(1, 3));
         else begin
            rd = 2'($urandom_range(1, 3));
            wr = 2'($urandom_range(1, 3));
         end
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         txn("rand", rd, wr, addr, $urandom, od, oe);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
